// File: rtl/id_ex_buf_pkg.sv
// rtl/id_ex_buf_pkg.sv - shared constants and state encoding for the decode/execute buffer
package id_ex_buf_pkg;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    // Encodings match the occupancy each state represents.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FULL  = 2'd1,
        BUF_SKID  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/id_ex_buf_slot.sv
// rtl/id_ex_buf_slot.sv - one payload register with valid flag, load enable and clear
module id_ex_buf_slot #(
    parameter int W = 134
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush discards any same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/id_ex_buf.sv
// rtl/id_ex_buf.sv - decode-to-execute pipeline buffer with two-entry skid and flush
module id_ex_buf
    import id_ex_buf_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [XLEN-1:0]    inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic [XLEN-1:0]    op1_i,
    input  logic [XLEN-1:0]    op2_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               rd_wen_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [XLEN-1:0]    inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               rd_wen_o,
    output logic [1:0]         occ_o
);

    localparam int PW = 4 * XLEN + RADDR_W + 1;

    buf_state_e    state, state_nxt;
    logic          main_valid, skid_valid;
    logic [PW-1:0] in_pl, main_pl, skid_pl, main_d, nop_pl;
    logic          main_load, main_clr, main_sel_skid;
    logic          skid_load, skid_clr;
    logic          accept, pop;

    assign in_pl  = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i};
    assign nop_pl = {XLEN'(INST_NOP), {(3 * XLEN + RADDR_W + 1){1'b0}}};

    // Ready comes straight from a flop, never from ex_ready_i or flush_i.
    assign id_ready_o = ~skid_valid;
    assign ex_valid_o = main_valid;
    assign accept     = id_valid_i & id_ready_o;
    assign pop        = main_valid & ex_ready_i;
    assign occ_o      = state;
    assign main_d     = main_sel_skid ? skid_pl : in_pl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush_i) begin
            // A same-cycle pop has already been consumed by execute; only held entries die.
            state_nxt = BUF_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_nxt = BUF_FULL;
                        main_load = 1'b1;
                    end
                end
                BUF_FULL: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = BUF_SKID;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = BUF_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                BUF_SKID: begin
                    if (pop) begin
                        state_nxt     = BUF_FULL;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = BUF_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    id_ex_buf_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clr   (main_clr),
        .load  (main_load),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_pl)
    );

    id_ex_buf_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     (in_pl),
        .valid (skid_valid),
        .q     (skid_pl)
    );

    // An empty MAIN slot presents addi x0,x0,0 with no register write.
    assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o} =
        main_valid ? main_pl : nop_pl;

endmodule

// File: tb/tb_id_ex_buf.sv
// tb/tb_id_ex_buf.sv - scoreboard bench for id_ex_buf
module tb_id_ex_buf;

    localparam int PW = 134;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic        id_ready_o;
    logic [31:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_wen_i = 1'b0;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b0;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;
    logic [1:0]  occ_o;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] exp_q[$];

    id_ex_buf dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .id_valid_i  (id_valid_i),
        .id_ready_o  (id_ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .rd_wen_i    (rd_wen_i),
        .ex_valid_o  (ex_valid_o),
        .ex_ready_i  (ex_ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .rd_addr_o   (rd_addr_o),
        .rd_wen_o    (rd_wen_o),
        .occ_o       (occ_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] rd, input logic wen);
        return {inst, pc, a, b, rd, wen};
    endfunction

    function automatic logic [PW-1:0] out_vec();
        return {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o};
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [PW-1:0] v, input logic vld);
        {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i} = v;
        id_valid_i = vld;
    endtask

    // Issues are sampled mid-low-phase, after inputs for the coming edge are settled.
    always @(negedge clk) begin
        #3;
        if (!rst && ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL issue: unexpected issue %h, scoreboard empty", out_vec());
            end else begin
                chk("issue", out_vec(), exp_q.pop_front());
            end
        end
    end

    logic [PW-1:0] nop, i_a1, i_a2, i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_h, i_i, i_j, i_k;

    initial begin
        nop  = mk(32'h00000013, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        i_a1 = mk(32'h00500093, 32'h80000000, 32'h0, 32'h5, 5'd1, 1'b1);
        i_a2 = mk(32'h00108133, 32'h80000004, 32'h5, 32'h5, 5'd2, 1'b1);
        i_a  = mk(32'h00A00193, 32'h80000008, 32'h0, 32'hA, 5'd3, 1'b1);
        i_b  = mk(32'h00B00213, 32'h8000000C, 32'h0, 32'hB, 5'd4, 1'b1);
        i_c  = mk(32'h00C00293, 32'h80000010, 32'h0, 32'hC, 5'd5, 1'b1);
        i_d  = mk(32'h01100313, 32'h80000014, 32'h1, 32'h11, 5'd6, 1'b1);
        i_e  = mk(32'h01200393, 32'h80000018, 32'h2, 32'h12, 5'd7, 1'b0);
        i_f  = mk(32'h01300413, 32'h8000001C, 32'h3, 32'h13, 5'd8, 1'b1);
        i_g  = mk(32'h01400493, 32'h80000020, 32'h4, 32'h14, 5'd9, 1'b1);
        i_h  = mk(32'h01500513, 32'h80000024, 32'h5, 32'h15, 5'd10, 1'b1);
        i_i  = mk(32'h01600593, 32'h80000028, 32'h6, 32'h16, 5'd11, 1'b1);
        i_j  = mk(32'h01700613, 32'h8000002C, 32'h7, 32'h17, 5'd12, 1'b1);
        i_k  = mk(32'hDEADB6B7, 32'h80000030, 32'hCAFEF00D, 32'h12345678, 5'd13, 1'b1);

        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("rst_outputs", out_vec(), nop);
        chk("rst_valid", PW'(ex_valid_o), PW'(0));
        chk("rst_ready", PW'(id_ready_o), PW'(1));
        chk("rst_occ", PW'(occ_o), PW'(0));

        // Streaming with execute always ready
        #1 ex_ready_i = 1'b1; drive(i_a1, 1'b1); exp_q.push_back(i_a1);
        @(negedge clk);
        chk("stream_a1", out_vec(), i_a1);
        chk("stream_occ1", PW'(occ_o), PW'(1));
        #1 drive(i_a2, 1'b1); exp_q.push_back(i_a2);
        @(negedge clk);
        chk("stream_a2", out_vec(), i_a2);
        chk("stream_occ2", PW'(occ_o), PW'(1));
        #1 drive(nop, 1'b0);
        @(negedge clk);
        chk("stream_drain_occ", PW'(occ_o), PW'(0));

        // Back-pressure: A to MAIN, B to SKID, C refused until release
        #1 ex_ready_i = 1'b0; drive(i_a, 1'b1); exp_q.push_back(i_a);
        @(negedge clk);
        chk("bp_full_occ", PW'(occ_o), PW'(1));
        chk("bp_full_ready", PW'(id_ready_o), PW'(1));
        #1 drive(i_b, 1'b1); exp_q.push_back(i_b);
        @(negedge clk);
        chk("bp_skid_occ", PW'(occ_o), PW'(2));
        chk("bp_skid_ready", PW'(id_ready_o), PW'(0));
        chk("bp_skid_head", out_vec(), i_a);
        #1 drive(i_c, 1'b1); exp_q.push_back(i_c);
        @(negedge clk);
        chk("bp_c_refused_occ", PW'(occ_o), PW'(2));
        chk("bp_c_refused_head", out_vec(), i_a);
        #1 ex_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_rel_b", out_vec(), i_b);
        chk("bp_rel_b_valid", PW'(ex_valid_o), PW'(1));
        @(negedge clk);
        chk("bp_rel_c", out_vec(), i_c);
        chk("bp_rel_c_occ", PW'(occ_o), PW'(1));
        #1 drive(nop, 1'b0);
        @(negedge clk);
        chk("bp_drained", PW'(occ_o), PW'(0));

        // Flush while in SKID with a same-cycle offer
        #1 ex_ready_i = 1'b0; drive(i_d, 1'b1);
        @(negedge clk);
        #1 drive(i_e, 1'b1);
        @(negedge clk);
        chk("fs_occ_before", PW'(occ_o), PW'(2));
        #1 flush_i = 1'b1; drive(i_f, 1'b1);
        @(negedge clk);
        chk("fs_outputs", out_vec(), nop);
        chk("fs_valid", PW'(ex_valid_o), PW'(0));
        chk("fs_occ", PW'(occ_o), PW'(0));
        chk("fs_ready", PW'(id_ready_o), PW'(1));
        #1 flush_i = 1'b0; drive(nop, 1'b0);
        @(negedge clk);
        chk("fs_lost", PW'(ex_valid_o), PW'(0));

        // Flush in FULL with execute popping the same cycle
        #1 ex_ready_i = 1'b1; drive(i_g, 1'b1); exp_q.push_back(i_g);
        @(negedge clk);
        chk("ff_head", out_vec(), i_g);
        #1 flush_i = 1'b1; drive(i_h, 1'b1);
        @(negedge clk);
        chk("ff_valid", PW'(ex_valid_o), PW'(0));
        chk("ff_occ", PW'(occ_o), PW'(0));
        #1 flush_i = 1'b0; drive(nop, 1'b0);
        @(negedge clk);
        chk("ff_no_dup", PW'(ex_valid_o), PW'(0));

        // Asynchronous reset while in SKID
        #1 ex_ready_i = 1'b0; drive(i_i, 1'b1);
        @(negedge clk);
        #1 drive(i_j, 1'b1);
        @(negedge clk);
        chk("ar_occ_before", PW'(occ_o), PW'(2));
        #1 drive(nop, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("ar_outputs", out_vec(), nop);
        chk("ar_valid", PW'(ex_valid_o), PW'(0));
        chk("ar_occ", PW'(occ_o), PW'(0));
        chk("ar_ready", PW'(id_ready_o), PW'(1));
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 ex_ready_i = 1'b1; drive(i_k, 1'b1); exp_q.push_back(i_k);
        @(negedge clk);
        chk("ar_first", out_vec(), i_k);
        #1 drive(nop, 1'b0);
        @(negedge clk);
        chk("ar_drained", PW'(occ_o), PW'(0));

        repeat (2) @(negedge clk);
        chk("sb_leftover", PW'(exp_q.size()), PW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
